// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result select, load size and entry state.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        READY = 2'b01,
        WAIT  = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data alignment: moves the addressed byte/half lane to the LSB and sign/zero-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rd_word_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [1:0]        off_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic              byte_sign;
    logic              half_sign;

    // Half-word lanes use only the upper offset bit, so misaligned halves snap to their lane.
    assign byte_sh   = rd_word_i >> {off_i, 3'b000};
    assign half_sh   = rd_word_i >> {off_i[1], 4'b0000};
    assign byte_lane = byte_sh[7:0];
    assign half_lane = half_sh[15:0];
    assign byte_sign = ~unsigned_i & byte_lane[7];
    assign half_sign = ~unsigned_i & half_lane[15];

    always_comb begin
        case (size_i)
            LD_BYTE: data_o = {{(DATA_W-8){byte_sign}}, byte_lane};
            LD_HALF: data_o = {{(DATA_W-16){half_sign}}, half_lane};
            default: data_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with result select and late-load handshake.
// Define WB_RETIRE_CNT_EN to build the retire counter; otherwise retire_count is tied to 0.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter bit R0_ZERO    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_pc_plus4,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic [1:0]            in_byte_off,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0]     write_data,
    output logic                  wb_stall_req,
    output logic [CNT_W-1:0]      retire_count
);

    wb_state_t             state_q, state_d;
    logic                  reg_write_q, reg_write_d;
    logic [1:0]            sel_q, sel_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     pc4_q, pc4_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [1:0]            ld_size_q, ld_size_d;
    logic                  ld_uns_q, ld_uns_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  hold;
    logic [DATA_W-1:0]     load_val;

    assign wb_stall_req = (state_q == WAIT);
    assign hold         = stall | wb_stall_req;

    always_comb begin
        state_d      = state_q;
        reg_write_d  = reg_write_q;
        sel_d        = sel_q;
        dest_d       = dest_q;
        alu_d        = alu_q;
        pc4_d        = pc4_q;
        imm_d        = imm_q;
        ld_size_d    = ld_size_q;
        ld_uns_d     = ld_uns_q;
        off_d        = off_q;
        buf_d        = buf_q;
        flush_pend_d = flush_pend_q;

        if (state_q == WAIT && rd_valid) begin
            buf_d   = rd_data;
            state_d = READY;
        end

        if (!hold) begin
            flush_pend_d = 1'b0;
            reg_write_d  = in_reg_write;
            sel_d        = in_wb_sel;
            dest_d       = in_dest;
            alu_d        = in_alu_result;
            pc4_d        = in_pc_plus4;
            imm_d        = in_imm;
            ld_size_d    = in_ld_size;
            ld_uns_d     = in_ld_unsigned;
            off_d        = in_byte_off;
            if (flush || flush_pend_q || !in_valid) begin
                state_d = EMPTY;
            end else if (in_wb_sel == WB_SEL_MEM) begin
                if (rd_valid) begin
                    buf_d   = rd_data;
                    state_d = READY;
                end else begin
                    state_d = WAIT;
                end
            end else begin
                state_d = READY;
            end
        end else if (flush) begin
            // A flush seen while the entry is held becomes the next capture.
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            reg_write_q  <= 1'b0;
            sel_q        <= WB_SEL_ALU;
            dest_q       <= '0;
            alu_q        <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            ld_size_q    <= LD_BYTE;
            ld_uns_q     <= 1'b0;
            off_q        <= '0;
            buf_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_write_q  <= reg_write_d;
            sel_q        <= sel_d;
            dest_q       <= dest_d;
            alu_q        <= alu_d;
            pc4_q        <= pc4_d;
            imm_q        <= imm_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            off_q        <= off_d;
            buf_q        <= buf_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    wb_load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .rd_word_i (buf_q),
        .size_i    (ld_size_q),
        .unsigned_i(ld_uns_q),
        .off_i     (off_q),
        .data_o    (load_val)
    );

    assign wb_reg_write = (state_q == READY) & reg_write_q & ~(R0_ZERO && (dest_q == '0));
    assign wb_dest      = dest_q;

    always_comb begin
        case (sel_q)
            WB_SEL_ALU:  write_data = alu_q;
            WB_SEL_MEM:  write_data = load_val;
            WB_SEL_LINK: write_data = pc4_q;
            default:     write_data = imm_q;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] retire_q;

    assign retire = (state_q == READY) & ~hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (retire) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: directed vectors plus a per-cycle reference model of the WB entry.
module tb_wb_stage_reg;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [1:0]  in_wb_sel = 2'b00;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [31:0] in_imm = '0;
    logic [1:0]  in_ld_size = 2'b00;
    logic        in_ld_unsigned = 1'b0;
    logic [1:0]  in_byte_off = 2'b00;
    logic [31:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] write_data;
    logic        wb_stall_req;
    logic [3:0]  retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage_reg #(
        .DATA_W(32), .REG_ADDR_W(5), .CNT_W(4), .R0_ZERO(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_wb_sel(in_wb_sel), .in_dest(in_dest), .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned), .in_byte_off(in_byte_off), .rd_data(rd_data),
        .rd_valid(rd_valid), .stall(stall), .flush(flush), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .write_data(write_data), .wb_stall_req(wb_stall_req),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction slot, tracked as "present" and "still missing load data".
    bit          m_full = 0, m_wait = 0, m_rw = 0, m_uns = 0, m_fpend = 0;
    logic [1:0]  m_sel = 0, m_size = 0, m_off = 0;
    logic [4:0]  m_dest = 0;
    logic [31:0] m_alu = 0, m_pc4 = 0, m_imm = 0, m_rd = 0;
    int unsigned m_ret = 0;

    function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] sz,
                                          input logic u, input logic [1:0] off);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * int'(off))) & 32'hFF;
            if (!u && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
            if (!u && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_value();
        case (m_sel)
            2'b00:   return m_alu;
            2'b01:   return align(m_rd, m_size, m_uns, m_off);
            2'b10:   return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef WB_RETIRE_CNT_EN
        return n % 16;
`else
        return 32'd0 & n;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit hold_now;
        if (!rst_n) begin
            m_full = 0; m_wait = 0; m_fpend = 0; m_ret = 0;
            m_rw = 0; m_sel = 0; m_dest = 0; m_alu = 0; m_pc4 = 0; m_imm = 0;
            m_size = 0; m_uns = 0; m_off = 0; m_rd = 0;
        end else begin
            hold_now = stall || (m_full && m_wait);
            if (m_full && m_wait) begin
                if (rd_valid) begin
                    m_rd = rd_data;
                    m_wait = 0;
                end
                if (flush) m_fpend = 1;
            end else if (hold_now) begin
                if (flush) m_fpend = 1;
            end else begin
                if (m_full) m_ret++;
                m_rw = in_reg_write; m_sel = in_wb_sel; m_dest = in_dest;
                m_alu = in_alu_result; m_pc4 = in_pc_plus4; m_imm = in_imm;
                m_size = in_ld_size; m_uns = in_ld_unsigned; m_off = in_byte_off;
                if (flush || m_fpend || !in_valid) begin
                    m_full = 0;
                end else begin
                    m_full = 1;
                    m_wait = (in_wb_sel == 2'b01) && !rd_valid;
                    if (in_wb_sel == 2'b01 && rd_valid) m_rd = rd_data;
                end
                m_fpend = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_we;
        if (!rst_n) begin
            chk("rst_we", 32'(wb_reg_write), 32'd0);
            chk("rst_stall", 32'(wb_stall_req), 32'd0);
            chk("rst_data", write_data, 32'd0);
            chk("rst_cnt", 32'(retire_count), 32'd0);
        end else begin
            exp_we = m_full && !m_wait && m_rw && (m_dest != 5'd0);
            chk("mdl_we", 32'(wb_reg_write), 32'(exp_we));
            chk("mdl_stall", 32'(wb_stall_req), 32'(m_full && m_wait));
            chk("mdl_cnt", 32'(retire_count), exp_cnt(m_ret));
            if (exp_we) begin
                chk("mdl_dest", 32'(wb_dest), 32'(m_dest));
                chk("mdl_data", write_data, m_value());
            end
        end
    end

    task automatic issue(input logic [1:0] sel, input logic [4:0] dest, input logic rw,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic rdv, input logic [31:0] rd);
        in_valid = 1'b1; in_wb_sel = sel; in_dest = dest; in_reg_write = rw;
        in_alu_result = alu; in_pc_plus4 = pc4; in_imm = imm;
        in_ld_size = size; in_ld_unsigned = uns; in_byte_off = off;
        rd_valid = rdv; rd_data = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] src;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b10, 2'b10, 1'b0, 2'b00, 32'h0000_0104, 32'h0000_0104};
        vecs[1] = '{2'b11, 2'b10, 1'b0, 2'b00, 32'hABCD_E000, 32'hABCD_E000};
        vecs[2] = '{2'b01, 2'b01, 1'b0, 2'b00, 32'h1234_F00F, 32'hFFFF_F00F};
        vecs[3] = '{2'b01, 2'b00, 1'b1, 2'b11, 32'h9A00_0000, 32'h0000_009A};
        vecs[4] = '{2'b01, 2'b00, 1'b0, 2'b01, 32'h0000_7F00, 32'h0000_007F};
        vecs[5] = '{2'b01, 2'b10, 1'b0, 2'b01, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[6] = '{2'b01, 2'b11, 1'b1, 2'b11, 32'h1357_9BDF, 32'h1357_9BDF};
        vecs[7] = '{2'b01, 2'b01, 1'b0, 2'b11, 32'hFFFE_0000, 32'hFFFF_FFFE};

        repeat (2) @(negedge clk);
        chk("reset_we", 32'(wb_reg_write), 32'd0);
        chk("reset_stall", 32'(wb_stall_req), 32'd0);
        chk("reset_cnt", 32'(retire_count), 32'd0);
        #2 rst_n = 1'b1;

        @(negedge clk);
        issue(WB_SEL_ALU, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("alu_we", 32'(wb_reg_write), 32'd1);
        chk("alu_dest", 32'(wb_dest), 32'd3);
        chk("alu_data", write_data, 32'h0000_1234);
        idle();

        @(negedge clk);
        issue(WB_SEL_MEM, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0, LD_BYTE, 1'b0, 2'd2, 1'b0, 32'h0);
        @(negedge clk);
        chk("lb_stall1", 32'(wb_stall_req), 32'd1);
        idle();
        @(negedge clk);
        chk("lb_stall2", 32'(wb_stall_req), 32'd1);
        chk("lb_we_wait", 32'(wb_reg_write), 32'd0);
        rd_valid = 1'b1; rd_data = 32'h0080_0000;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("lb_stall_end", 32'(wb_stall_req), 32'd0);
        chk("lb_we", 32'(wb_reg_write), 32'd1);
        chk("lb_data", write_data, 32'hFFFF_FF80);

        issue(WB_SEL_MEM, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0, LD_HALF, 1'b1, 2'd2, 1'b1, 32'h8001_ABCD);
        @(negedge clk);
        idle();
        chk("lhu_stall", 32'(wb_stall_req), 32'd0);
        chk("lhu_data", write_data, 32'h0000_8001);

        foreach (vecs[i]) begin
            issue(vecs[i].sel, 5'(i + 10), 1'b1,
                  vecs[i].sel == WB_SEL_ALU  ? vecs[i].src : 32'h1111_1111,
                  vecs[i].sel == WB_SEL_LINK ? vecs[i].src : 32'h2222_2222,
                  vecs[i].sel == WB_SEL_IMM  ? vecs[i].src : 32'h3333_3333,
                  vecs[i].size, vecs[i].uns, vecs[i].off, vecs[i].sel == WB_SEL_MEM,
                  vecs[i].sel == WB_SEL_MEM ? vecs[i].src : 32'h4444_4444);
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), write_data, vecs[i].exp);
        end
        idle();

        @(negedge clk);
        issue(WB_SEL_ALU, 5'd0, 1'b1, 32'h55, 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("r0_we", 32'(wb_reg_write), 32'd0);
        idle();

        @(negedge clk);
        issue(WB_SEL_ALU, 5'd7, 1'b1, 32'hBEEF, 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        chk("sf_we0", 32'(wb_reg_write), 32'd1);
        issue(WB_SEL_ALU, 5'd9, 1'b1, 32'h999, 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        stall = 1'b1;
        @(negedge clk);
        chk("sf_we1", 32'(wb_reg_write), 32'd1);
        chk("sf_dest1", 32'(wb_dest), 32'd7);
        flush = 1'b1;
        @(negedge clk);
        chk("sf_we2", 32'(wb_reg_write), 32'd1);
        chk("sf_dest2", 32'(wb_dest), 32'd7);
        flush = 1'b0;
        @(negedge clk);
        chk("sf_we3", 32'(wb_reg_write), 32'd1);
        chk("sf_data3", write_data, 32'h0000_BEEF);
        stall = 1'b0;
        @(negedge clk);
        chk("sf_bubble", 32'(wb_reg_write), 32'd0);
        @(negedge clk);
        chk("sf_next_dest", 32'(wb_dest), 32'd9);
        idle();

        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            issue(WB_SEL_ALU, 5'(i + 1), 1'b1, 32'(i), 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        end
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("wrap_15", 32'(retire_count), exp_cnt(15));
        issue(WB_SEL_ALU, 5'd1, 1'b1, 32'h77, 32'h0, 32'h0, LD_WORD, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("wrap_0", 32'(retire_count), 32'd0);

        issue(WB_SEL_MEM, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, LD_BYTE, 1'b0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        idle();
        chk("rw_stall", 32'(wb_stall_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_rst_stall", 32'(wb_stall_req), 32'd0);
        chk("rw_rst_we", 32'(wb_reg_write), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rd_valid = 1'b1; rd_data = 32'h0000_00FF;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("late_we", 32'(wb_reg_write), 32'd0);
        chk("late_stall", 32'(wb_stall_req), 32'd0);
        @(negedge clk);
        chk("late_we2", 32'(wb_reg_write), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
